// File: rtl/ps2_kbd_decoder_pkg.sv
// Shared constants for the PS/2 keyboard decoder: prefix bytes and frame FSM states.
package ps2_kbd_decoder_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  // Bytes that follow an E1 prefix and are swallowed before the Pause event
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_kbd_decoder_frame_rx.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, frame FSM and
// mid-frame timeout. Emits one byte per good frame or an error pulse.
module ps2_frame_rx
  import ps2_kbd_decoder_pkg::*;
#(
  parameter int FILTER  = 3,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          edge_fall;
  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tcnt;

  // Two-flop synchronisers; both idle high so reset never fakes a falling edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // A new clock level is accepted once it has been seen FILTER cycles in a row
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER - 1)) begin
      filt <= clk_s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // The filtered clock is about to fall this cycle; data is sampled alongside
  assign edge_fall = filt && !clk_s2 && (fcnt == FW'(FILTER - 1));
  assign busy      = (state != ST_IDLE);

  // Frame FSM with timeout; an edge in the timeout cycle keeps the frame alive
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_ok      <= 1'b0;
      tcnt        <= '0;
      byte_data   <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      if (edge_fall || state == ST_IDLE) tcnt <= '0;
      else                               tcnt <= tcnt + 1'b1;

      case (state)
        ST_IDLE: if (edge_fall && !dat_s2) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
        ST_DATA: if (edge_fall) begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: if (edge_fall) begin
          par_ok <= (^shreg) ^ dat_s2;
          state  <= ST_STOP;
        end
        ST_STOP: if (edge_fall) begin
          if (par_ok && dat_s2) begin
            byte_data   <= shreg;
            byte_strobe <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (state != ST_IDLE && !edge_fall && tcnt == TW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder top: frame receiver plus the prefix folding layer that
// turns E0/F0/E1 sequences into single key events.
module ps2_kbd_decoder
  import ps2_kbd_decoder_pkg::*;
#(
  parameter int FILTER  = 3,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       busy,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released
);

  logic       ext_pend, rel_pend;
  logic [2:0] skip_cnt;

  ps2_frame_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Prefix folding: pending flags, Pause skip sequence, key event registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
      skip_cnt     <= '0;
      key_strobe   <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
        skip_cnt <= '0;
      end else if (byte_strobe) begin
        if (skip_cnt != '0) begin
          // Pause tail bytes (including embedded prefixes) are eaten here
          skip_cnt <= skip_cnt - 1'b1;
          if (skip_cnt == 3'd1) begin
            key_strobe   <= 1'b1;
            key_code     <= PS2_PFX_PAUSE;
            key_extended <= 1'b0;
            key_released <= 1'b0;
          end
        end else begin
          case (byte_data)
            PS2_PFX_EXT:   ext_pend <= 1'b1;
            PS2_PFX_REL:   rel_pend <= 1'b1;
            PS2_PFX_PAUSE: skip_cnt <= PS2_PAUSE_SKIP;
            default: begin
              key_strobe   <= 1'b1;
              key_code     <= byte_data;
              key_extended <= ext_pend;
              key_released <= rel_pend;
              ext_pend     <= 1'b0;
              rel_pend     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
